// File: rtl/pipe_mux_reg.sv
// NIN:1 selector feeding a DEPTH-stage register pipeline with valid tracking,
// stall/flush control and a sticky out-of-range select flag.
module pipe_mux_reg #(
    parameter int unsigned W     = 32,
    parameter int unsigned NIN   = 4,
    parameter int unsigned DEPTH = 1,
    localparam int unsigned SELW = $clog2(NIN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NIN*W-1:0] in_bus,
    input  logic [SELW-1:0]  sel,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             err_clr,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             sel_err
);

    if (DEPTH < 1 || DEPTH > 8) begin : gen_bad_depth
        $error("pipe_mux_reg: DEPTH must be in 1..8");
    end
    if (NIN < 2 || W < 1) begin : gen_bad_shape
        $error("pipe_mux_reg: need NIN >= 2 and W >= 1");
    end

    logic [W-1:0]     mux_d;
    logic             sel_oob;
    logic             advance;
    logic [W-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             err_q;

    // Out-of-range selects resolve to zero data; only reachable for non-power-of-2 NIN.
    always_comb begin
        mux_d = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            if (32'(sel) == i) begin
                mux_d = in_bus[i*W +: W];
            end
        end
    end

    assign sel_oob = (32'(sel) >= NIN);
    assign advance = !flush && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? mux_d : '0;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    // Set takes priority over clear so a fresh error is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (advance && in_valid && sel_oob) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign sel_err   = err_q;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Directed bench for pipe_mux_reg: DEPTH=1 and DEPTH=3 with NIN=4, plus NIN=5 for sel_err.
module tb_pipe_mux_reg;

    localparam logic [31:0] A = 32'hA0A0_0001;
    localparam logic [31:0] B = 32'hB0B0_0002;
    localparam logic [31:0] C = 32'hC0C0_0003;
    localparam logic [31:0] D = 32'hD0D0_0004;
    localparam logic [31:0] E = 32'hE0E0_0005;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [127:0] bus4;
    logic [1:0]   sel4;
    logic         vld4, stall4, flush4, clr4;
    logic [31:0]  d1_data, d3_data;
    logic         d1_valid, d3_valid, d1_err, d3_err;

    logic [159:0] bus5;
    logic [2:0]   sel5;
    logic         vld5, stall5, flush5, clr5;
    logic [31:0]  n5_data;
    logic         n5_valid, n5_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_mux_reg #(.W(32), .NIN(4), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_bus(bus4), .sel(sel4), .in_valid(vld4),
        .stall(stall4), .flush(flush4), .err_clr(clr4),
        .out_data(d1_data), .out_valid(d1_valid), .sel_err(d1_err)
    );

    pipe_mux_reg #(.W(32), .NIN(4), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_bus(bus4), .sel(sel4), .in_valid(vld4),
        .stall(stall4), .flush(flush4), .err_clr(clr4),
        .out_data(d3_data), .out_valid(d3_valid), .sel_err(d3_err)
    );

    pipe_mux_reg #(.W(32), .NIN(5), .DEPTH(1)) u_n5 (
        .clk(clk), .rst_n(rst_n), .in_bus(bus5), .sel(sel5), .in_valid(vld5),
        .stall(stall5), .flush(flush5), .err_clr(clr5),
        .out_data(n5_data), .out_valid(n5_valid), .sel_err(n5_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush4 = 1'b1;
        step();
        flush4 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_total++; if (d1_data !== 32'd0) $display("FAIL reset_d1_data got=%h exp=0", d1_data); else n_pass++;
        n_total++; if (d1_valid !== 1'b0) $display("FAIL reset_d1_valid got=%b exp=0", d1_valid); else n_pass++;
        n_total++; if (d3_data !== 32'd0) $display("FAIL reset_d3_data got=%h exp=0", d3_data); else n_pass++;
        n_total++; if (d3_valid !== 1'b0) $display("FAIL reset_d3_valid got=%b exp=0", d3_valid); else n_pass++;
        n_total++; if (n5_err !== 1'b0) $display("FAIL reset_n5_err got=%b exp=0", n5_err); else n_pass++;
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_depth1_select();
        logic [1:0]  s_tab [5] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        logic        v_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] e_tab [5] = '{C, A, D, B, 32'd0};
        bus4 = {D, C, B, A};
        for (int i = 0; i < 5; i++) begin
            sel4 = s_tab[i];
            vld4 = v_tab[i];
            step();
            n_total++;
            if (d1_data !== e_tab[i]) $display("FAIL d1_sel%0d_data got=%h exp=%h", i, d1_data, e_tab[i]);
            else n_pass++;
            n_total++;
            if (d1_valid !== v_tab[i]) $display("FAIL d1_sel%0d_valid got=%b exp=%b", i, d1_valid, v_tab[i]);
            else n_pass++;
        end
        vld4 = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] in_tab [7] = '{32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004,
                                    32'd0, 32'd0, 32'd0};
        logic        iv_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ed_tab [7] = '{32'd0, 32'd0, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                                    32'h1000_0004, 32'd0};
        logic        ev_tab [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_flush();
        sel4 = 2'd0;
        for (int i = 0; i < 7; i++) begin
            bus4 = {D, C, B, in_tab[i]};
            vld4 = iv_tab[i];
            step();
            n_total++;
            if (d3_data !== ed_tab[i] || d3_valid !== ev_tab[i])
                $display("FAIL stream_edge%0d got=%b/%h exp=%b/%h", i + 1, d3_valid, d3_data,
                         ev_tab[i], ed_tab[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic        st_tab [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
        logic        iv_tab [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic [31:0] in_tab [9] = '{32'h5000_0000, 32'h5000_0011, 32'h5000_0022, 32'h5000_0033,
                                    32'h5000_0033, 32'h5000_0033, 32'd0, 32'd0, 32'd0};
        logic        ev_tab [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] ed_tab [9] = '{32'd0, 32'd0, 32'h5000_0000, 32'h5000_0000, 32'h5000_0000,
                                    32'h5000_0011, 32'h5000_0022, 32'h5000_0033, 32'd0};
        do_flush();
        sel4 = 2'd0;
        for (int i = 0; i < 9; i++) begin
            stall4 = st_tab[i];
            vld4   = iv_tab[i];
            bus4   = {D, C, B, in_tab[i]};
            step();
            n_total++;
            if (d3_data !== ed_tab[i] || d3_valid !== ev_tab[i])
                $display("FAIL stall_cycle%0d got=%b/%h exp=%b/%h", i + 1, d3_valid, d3_data,
                         ev_tab[i], ed_tab[i]);
            else n_pass++;
        end
        stall4 = 1'b0;
    endtask

    task automatic test_flush_stall();
        do_flush();
        sel4 = 2'd1;
        bus4 = {D, C, B, A};
        vld4 = 1'b1;
        repeat (3) step();
        n_total++;
        if (d3_valid !== 1'b1 || d3_data !== B)
            $display("FAIL flush_prefill got=%b/%h exp=1/%h", d3_valid, d3_data, B);
        else n_pass++;
        flush4 = 1'b1;
        stall4 = 1'b1;
        step();
        flush4 = 1'b0;
        stall4 = 1'b0;
        vld4   = 1'b0;
        n_total++;
        if (d3_valid !== 1'b0 || d3_data !== 32'd0)
            $display("FAIL flush_stall_out got=%b/%h exp=0/0", d3_valid, d3_data);
        else n_pass++;
        // Inner stages must have been cleared too, not just the output stage.
        for (int i = 0; i < 2; i++) begin
            step();
            n_total++;
            if (d3_valid !== 1'b0 || d3_data !== 32'd0)
                $display("FAIL flush_drain%0d got=%b/%h exp=0/0", i, d3_valid, d3_data);
            else n_pass++;
        end
    endtask

    task automatic test_sel_err();
        logic [2:0]  s_tab [9]  = '{3'd4, 3'd6, 3'd6, 3'd1, 3'd7, 3'd5, 3'd5, 3'd0, 3'd0};
        logic        v_tab [9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
        logic        st_tab [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic        fl_tab [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic        cl_tab [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
        logic [31:0] ed_tab [9] = '{E, 32'd0, 32'd0, B, B, 32'd0, 32'd0, 32'd0, A};
        logic        ev_tab [9] = '{1, 1, 1, 1, 1, 0, 1, 0, 1};
        logic        ee_tab [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        bus5 = {E, D, C, B, A};
        for (int i = 0; i < 9; i++) begin
            sel5   = s_tab[i];
            vld5   = v_tab[i];
            stall5 = st_tab[i];
            flush5 = fl_tab[i];
            clr5   = cl_tab[i];
            step();
            n_total++;
            if (n5_data !== ed_tab[i] || n5_valid !== ev_tab[i])
                $display("FAIL n5_out%0d got=%b/%h exp=%b/%h", i, n5_valid, n5_data, ev_tab[i],
                         ed_tab[i]);
            else n_pass++;
            n_total++;
            if (n5_err !== ee_tab[i]) $display("FAIL n5_err%0d got=%b exp=%b", i, n5_err, ee_tab[i]);
            else n_pass++;
        end
        {vld5, stall5, flush5, clr5} = 4'b0;
    endtask

    task automatic test_async_reset();
        do_flush();
        sel4 = 2'd3;
        bus4 = {D, C, B, A};
        vld4 = 1'b1;
        sel5 = 3'd5;
        vld5 = 1'b1;
        repeat (3) step();
        vld5 = 1'b0;
        n_total++;
        if (d3_valid !== 1'b1 || n5_err !== 1'b1)
            $display("FAIL arst_prefill got=%b/%b exp=1/1", d3_valid, n5_err);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (d3_valid !== 1'b0 || d3_data !== 32'd0)
            $display("FAIL arst_d3_out got=%b/%h exp=0/0", d3_valid, d3_data);
        else n_pass++;
        n_total++;
        if (n5_err !== 1'b0) $display("FAIL arst_n5_err got=%b exp=0", n5_err); else n_pass++;
        #2 rst_n = 1'b1;
        sel4 = 2'd2;
        for (int i = 1; i <= 3; i++) begin
            step();
            vld4 = 1'b0;
            n_total++;
            if (i < 3 && d3_valid !== 1'b0)
                $display("FAIL arst_release%0d got=%b exp=0", i, d3_valid);
            else if (i == 3 && (d3_valid !== 1'b1 || d3_data !== C))
                $display("FAIL arst_release%0d got=%b/%h exp=1/%h", i, d3_valid, d3_data, C);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus4 = '0; sel4 = '0; vld4 = 1'b0; stall4 = 1'b0; flush4 = 1'b0; clr4 = 1'b0;
        bus5 = '0; sel5 = '0; vld5 = 1'b0; stall5 = 1'b0; flush5 = 1'b0; clr5 = 1'b0;
        test_reset();
        test_depth1_select();
        test_stream();
        test_stall();
        test_flush_stall();
        test_sel_err();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
